// File: rtl/simon_autoplayer.sv
// Simon Says auto-player: records the LED sequence of a round and replays it as active-low button presses.
// Optional macro SIMON_AUTOPLAYER_ERR_INJ_EN adds inj_err, which corrupts the last replayed element.
module simon_autoplayer #(
  parameter int MAX_LEN   = 32,
  parameter int IDX_W     = 6,
  parameter int PRESS_CYC = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       leds,
  input  logic             led_stb,
  input  logic             is_player,
  input  logic             correct,
  input  logic             wrong,
  output logic [3:0]       btn_n,
  output logic [IDX_W-1:0] seq_len,
  output logic             busy,
  output logic             overflow,
  output logic             bad_led,
  output logic [7:0]       wins
`ifdef SIMON_AUTOPLAYER_ERR_INJ_EN
  ,
  input  logic             inj_err
`endif
);

  typedef enum logic [1:0] {S_CAPTURE, S_PRESS, S_GAP, S_DONE} state_e;

  localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_MAX = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [IDX_W-1:0] MAX_LEN_L = IDX_W'(MAX_LEN);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] seq_len_q, seq_len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       btn_n_q, btn_n_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             bad_led_q, bad_led_d;
  logic [7:0]       wins_q, wins_d;
  logic             inj_q, inj_d;
  logic             is_player_q, correct_q;

  logic [1:0]       mem_q [MAX_LEN];
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  logic             led_onehot;
  logic [1:0]       led_code;
  logic [1:0]       stored_code;
  logic [1:0]       press_code;
  logic             player_rise, player_fall, correct_rise;
  logic             inj_in;
  logic             unused_wrong;

`ifdef SIMON_AUTOPLAYER_ERR_INJ_EN
  assign inj_in = inj_err;
`else
  assign inj_in = 1'b0;
`endif

  // A failing round is ended by the game dropping is_player; wrong itself needs no handling.
  assign unused_wrong = wrong;

  assign player_rise  = is_player && !is_player_q;
  assign player_fall  = !is_player && is_player_q;
  assign correct_rise = correct && !correct_q;

  always_comb begin
    led_onehot = 1'b1;
    led_code   = 2'd0;
    case (leds)
      4'b0001: led_code = 2'd0;
      4'b0010: led_code = 2'd1;
      4'b0100: led_code = 2'd2;
      4'b1000: led_code = 2'd3;
      default: led_onehot = 1'b0;
    endcase
  end

  assign stored_code = mem_q[idx_q[AW-1:0]];
  assign press_code  = (inj_q && (idx_q == (seq_len_q - IDX_W'(1)))) ? (stored_code + 2'd1) : stored_code;

  always_comb begin
    state_d    = state_q;
    seq_len_d  = seq_len_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    btn_n_d    = 4'b1111;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    bad_led_d  = bad_led_q;
    wins_d     = wins_q;
    inj_d      = inj_q;
    wr_en      = 1'b0;
    wr_addr    = seq_len_q[AW-1:0];

    case (state_q)
      S_CAPTURE: begin
        if (led_stb && !is_player) begin
          if (!led_onehot) begin
            bad_led_d = 1'b1;
          end else if (seq_len_q == MAX_LEN_L) begin
            overflow_d = 1'b1;
          end else begin
            wr_en     = 1'b1;
            seq_len_d = seq_len_q + IDX_W'(1);
          end
        end
        if (player_rise) begin
          idx_d = '0;
          cnt_d = '0;
          inj_d = inj_in;
          if (seq_len_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PRESS;
            busy_d  = 1'b1;
          end
        end
      end
      S_PRESS: begin
        // btn_n is registered, so the low phase trails the state by one cycle.
        btn_n_d = ~(4'b0001 << press_code);
        if (cnt_q == CNT_W'(PRESS_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if ((idx_q + IDX_W'(1)) < seq_len_q) begin
            state_d = S_PRESS;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        busy_d = 1'b0;
      end
      default: state_d = S_CAPTURE;
    endcase

    // Leaving the player turn starts a fresh capture; a strobe in the same cycle becomes element 0.
    if (player_fall && (state_q != S_CAPTURE)) begin
      state_d   = S_CAPTURE;
      btn_n_d   = 4'b1111;
      busy_d    = 1'b0;
      cnt_d     = '0;
      seq_len_d = '0;
      wr_addr   = '0;
      if (led_stb) begin
        if (!led_onehot) begin
          bad_led_d = 1'b1;
        end else begin
          wr_en     = 1'b1;
          seq_len_d = IDX_W'(1);
        end
      end
    end

    if (correct_rise && (state_q != S_CAPTURE)) begin
      wins_d = wins_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CAPTURE;
      seq_len_q   <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      btn_n_q     <= 4'b1111;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      bad_led_q   <= 1'b0;
      wins_q      <= 8'd0;
      inj_q       <= 1'b0;
      is_player_q <= 1'b0;
      correct_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_len_q   <= seq_len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      btn_n_q     <= btn_n_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      bad_led_q   <= bad_led_d;
      wins_q      <= wins_d;
      inj_q       <= inj_d;
      is_player_q <= is_player;
      correct_q   <= correct;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= led_code;
    end
  end

  assign btn_n    = btn_n_q;
  assign seq_len  = seq_len_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign bad_led  = bad_led_q;
  assign wins     = wins_q;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Randomized self-checking bench for simon_autoplayer against a queue-based model of the game rounds.
module tb_simon_autoplayer;
  localparam int MAX_LEN   = 32;
  localparam int IDX_W     = 6;
  localparam int PRESS_CYC = 4;
  localparam int GAP_CYC   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       leds = 4'h0;
  logic             led_stb = 1'b0;
  logic             is_player = 1'b0;
  logic             correct = 1'b0;
  logic             wrong = 1'b0;
  logic             inj_err = 1'b0;
  logic [3:0]       btn_n;
  logic [IDX_W-1:0] seq_len;
  logic             busy, overflow, bad_led;
  logic [7:0]       wins;

  int errors = 0;
  int checks = 0;

  int   exp_q[$];
  logic exp_ovf = 1'b0;
  logic exp_bad = 1'b0;
  int   exp_wins = 0;

  always #5 clk = ~clk;

  simon_autoplayer #(
    .MAX_LEN(MAX_LEN), .IDX_W(IDX_W), .PRESS_CYC(PRESS_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .leds(leds), .led_stb(led_stb), .is_player(is_player),
    .correct(correct), .wrong(wrong), .btn_n(btn_n), .seq_len(seq_len), .busy(busy),
    .overflow(overflow), .bad_led(bad_led), .wins(wins)
`ifdef SIMON_AUTOPLAYER_ERR_INJ_EN
    , .inj_err(inj_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int code_of(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic logic [3:0] rand_onehot();
    logic [3:0] v;
    v = 4'b0001 << $urandom_range(0, 3);
    return v;
  endfunction

  // One strobe followed by an idle cycle; the model applies the capture rules.
  task automatic strobe(input logic [3:0] v);
    leds = v;
    led_stb = 1'b1;
    tick();
    led_stb = 1'b0;
    leds = 4'h0;
    if ($onehot(v)) begin
      if (exp_q.size() < MAX_LEN) exp_q.push_back(code_of(v));
      else exp_ovf = 1'b1;
    end else begin
      exp_bad = 1'b1;
    end
    tick();
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_seq_len"}, seq_len, exp_q.size());
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_bad_led"}, bad_led, exp_bad);
    check({tag, "_wins"}, wins, exp_wins);
  endtask

  task automatic wait_first_press(output bit seen);
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (btn_n !== 4'hF) seen = 1;
    end
    check("first_press_seen", seen, 1);
  endtask

  // Raise is_player and check the full press/gap timeline against the model queue.
  task automatic replay(input bit inj);
    int n;
    int code;
    bit seen;
    logic [3:0] exp_btn;
    n = exp_q.size();
    is_player = 1'b1;
    if (n == 0) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        check("empty_btn", btn_n, 4'hF);
      end
      check("empty_busy", busy, 0);
      return;
    end
    wait_first_press(seen);
    if (!seen) return;
    check("busy_replay", busy, 1);
    for (int i = 0; i < n; i++) begin
      code = exp_q[i];
      if (inj && i == n - 1) code = (code + 1) % 4;
      exp_btn = ~(4'b0001 << code);
      for (int c = 0; c < PRESS_CYC; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        check("press", btn_n, exp_btn);
      end
      for (int c = 0; c < GAP_CYC; c++) begin
        @(negedge clk);
        check("gap", btn_n, 4'hF);
      end
    end
    repeat (2) @(negedge clk);
    check("done_btn", btn_n, 4'hF);
    check("done_busy", busy, 0);
    check("done_seq_len", seq_len, n);
  endtask

  task automatic end_round(input bit do_correct, input bit do_wrong);
    if (do_correct || do_wrong) begin
      correct = do_correct;
      wrong = do_wrong;
      tick();
      correct = 1'b0;
      wrong = 1'b0;
      if (do_correct) exp_wins = (exp_wins + 1) % 256;
    end
    is_player = 1'b0;
    tick();
    tick();
    exp_q.delete();
    check_flags("end_round");
    $display("round end: correct=%0d wrong=%0d wins=%0d", do_correct, do_wrong, wins);
  endtask

  // Drop is_player at the first cycle of the second press, optionally with a coinciding strobe.
  task automatic abort_test(input bit with_strobe, input logic [3:0] sv);
    bit seen;
    logic [3:0] second;
    second = ~(4'b0001 << exp_q[1]);
    is_player = 1'b1;
    wait_first_press(seen);
    if (!seen) return;
    repeat (PRESS_CYC + GAP_CYC) @(negedge clk);
    check("abort_second_press", btn_n, second);
    is_player = 1'b0;
    if (with_strobe) begin
      leds = sv;
      led_stb = 1'b1;
    end
    tick();
    led_stb = 1'b0;
    leds = 4'h0;
    @(negedge clk);
    exp_q.delete();
    if (with_strobe) exp_q.push_back(code_of(sv));
    check("abort_btn", btn_n, 4'hF);
    check("abort_busy", busy, 0);
    check("abort_seq_len", seq_len, exp_q.size());
    $display("abort: strobe=%0d seq_len=%0d", with_strobe, seq_len);
  endtask

  initial begin
    int n;
    logic [3:0] v;
    bit seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_btn", btn_n, 4'hF);
    check("rst_busy", busy, 0);
    check_flags("rst");
    rst_n = 1'b1;
    tick();

    // Empty round, then a correct pulse in DONE and one in CAPTURE (not counted).
    replay(0);
    end_round(1, 0);
    correct = 1'b1;
    tick();
    correct = 1'b0;
    tick();
    check("capture_correct_ignored", wins, exp_wins);

    // Directed three-element round.
    strobe(4'b0100);
    strobe(4'b0001);
    strobe(4'b0001);
    check_flags("directed_cap");
    replay(0);
    end_round(1, 1);

    // Non-one-hot strobe is dropped and flagged.
    strobe(4'b0010);
    strobe(4'b0110);
    check_flags("bad_cap");
    replay(0);
    end_round(0, 1);

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      for (int e = 0; e < n; e++) begin
        if ($urandom_range(0, 7) == 0) begin
          do v = 4'($urandom_range(0, 15)); while ($onehot(v));
          strobe(v);
        end
        strobe(rand_onehot());
      end
      check_flags("rand_cap");
      $display("random round %0d: len=%0d", r, exp_q.size());
      replay(0);
      end_round($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    // Abort without and with a coinciding strobe.
    for (int k = 0; k < 3; k++) strobe(rand_onehot());
    abort_test(0, 4'h0);
    check_flags("abort0");
    for (int k = 0; k < 3; k++) strobe(rand_onehot());
    abort_test(1, 4'b0010);
    check_flags("abort1");
    replay(0);
    end_round(1, 0);

    // Buffer overflow with a full-length replay.
    for (int k = 0; k < MAX_LEN + 1; k++) strobe(rand_onehot());
    check("ovf_seq_len", seq_len, MAX_LEN);
    check("ovf_flag", overflow, 1);
    replay(0);
    end_round(0, 0);

    // Wins wrap: pulse correct in DONE until 255, then once more.
    replay(0);
    correct = 1'b1;
    wrong = 1'b1;
    tick();
    correct = 1'b0;
    wrong = 1'b0;
    tick();
    exp_wins = (exp_wins + 1) % 256;
    check("correct_and_wrong", wins, exp_wins);
    for (int g = 0; g < 300 && exp_wins != 255; g++) begin
      correct = 1'b1;
      tick();
      correct = 1'b0;
      tick();
      exp_wins++;
    end
    check("wins_255", wins, 255);
    correct = 1'b1;
    tick();
    correct = 1'b0;
    tick();
    exp_wins = 0;
    check("wins_wrap", wins, 0);
    end_round(0, 0);

    // Asynchronous reset in the middle of a press.
    strobe(4'b1000);
    strobe(4'b0100);
    is_player = 1'b1;
    wait_first_press(seen);
    rst_n = 1'b0;
    is_player = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_bad = 1'b0;
    exp_wins = 0;
    check("midreset_btn", btn_n, 4'hF);
    check("midreset_busy", busy, 0);
    check_flags("midreset");
    @(negedge clk);
    check("midreset_hold_btn", btn_n, 4'hF);
    rst_n = 1'b1;
    tick();

`ifdef SIMON_AUTOPLAYER_ERR_INJ_EN
    strobe(4'b1000);
    strobe(4'b0010);
    inj_err = 1'b1;
    replay(1);
    inj_err = 1'b0;
    end_round(0, 1);
`endif

    // Post-reset round to confirm normal operation resumes.
    strobe(4'b0001);
    strobe(4'b1000);
    replay(0);
    end_round(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
